// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio -- memory-mapped 8N1 UART transmitter on the core's data bus.
//
// Stores into a 3-register window push bytes into a small TX FIFO; a serial
// engine drains the FIFO onto the tx pin, LSB first, one start and one stop bit.
//
// Register window (byte offsets from BASE_ADDR):
//   0x0 TXDATA   write-only, reads 0; any store size pushes data[7:0]
//   0x4 STATUS   bit0 busy, bit1 full, bit2 empty, bit3 overflow (sticky),
//                bits[7:4] FIFO count, bit8 parity-enabled;
//                a store with data[3]=1 clears overflow
//   0x8 DIVISOR  clocks per bit, 16 bit; sb writes [7:0], sh/sw write [15:0]
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   dmem_address   byte address from the core
//   dmem_data_in   store data
//   dmem_wren      store strobe
//   funct3         access size: 000 byte, 001 half, 010 word
//   dmem_data_out  registered read data (valid the cycle after the address)
//   sel_out        registered; high when dmem_data_out comes from this block
//   tx             serial line, idle high
//
// Build option: define UART_TX_PARITY_EN to append an even parity bit after
// the data bits (11-bit frames) and to report bit8=1 in STATUS.

module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFFFFE0,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  input  logic        dmem_wren,
  input  logic [2:0]  funct3,
  output logic [31:0] dmem_data_out,
  output logic        sel_out,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_FLAG = 1'b1;
`else
  localparam logic PAR_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       w_in_win;
  logic [3:0] w_off;
  logic       w_hit_tx, w_hit_st, w_hit_dv, w_hit;
  logic       w_wr_tx, w_wr_st, w_wr_dv;

  assign w_in_win = (dmem_address[31:4] == BASE_ADDR[31:4]);
  assign w_off    = dmem_address[3:0];
  assign w_hit_tx = w_in_win && (w_off == 4'h0);
  assign w_hit_st = w_in_win && (w_off == 4'h4);
  assign w_hit_dv = w_in_win && (w_off == 4'h8);
  assign w_hit    = w_hit_tx || w_hit_st || w_hit_dv;
  assign w_wr_tx  = dmem_wren && w_hit_tx;
  assign w_wr_st  = dmem_wren && w_hit_st;
  assign w_wr_dv  = dmem_wren && w_hit_dv;

  // Upper store bits and funct3[2] carry no meaning for this block.
  logic w_unused_ok;
  assign w_unused_ok = ^{dmem_data_in[31:16], funct3[2]};

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_full, w_empty, w_push, w_pop, w_drop;
  logic [7:0]    w_head;

  assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_head  = r_mem[r_rptr];
  // A full FIFO still accepts a byte when the engine pops in the same cycle.
  assign w_push  = w_wr_tx && (!w_full || w_pop);
  assign w_drop  = w_wr_tx && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= dmem_data_in[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // DIVISOR and sticky overflow
  // ---------------------------------------------------------------------------
  logic [15:0] r_div;
  logic        r_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= DEFAULT_DIV;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_dv) begin
        if (funct3[1:0] == 2'b00) r_div[7:0] <= dmem_data_in[7:0];
        else                      r_div      <= dmem_data_in[15:0];
      end
      if (w_drop)                         r_ovf <= 1'b1;
      else if (w_wr_st && dmem_data_in[3]) r_ovf <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Serial engine
  // ---------------------------------------------------------------------------
  state_t      r_state, w_state_n;
  logic [7:0]  r_shift, w_shift_n;
  logic [2:0]  r_bit_cnt, w_bit_n;
  logic [15:0] r_cyc, w_cyc_n;
  logic [15:0] r_divl, w_divl_n;
  logic        r_par, w_par_n;
  logic        r_tx, w_tx_n;
  logic [15:0] w_div_eff;
  logic        w_bit_end;

  // A zero divisor would never end a bit; treat it as one clock per bit.
  assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_bit_end = (r_cyc == r_divl - 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_cyc     <= '0;
      r_divl    <= 16'd1;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_n;
      r_shift   <= w_shift_n;
      r_bit_cnt <= w_bit_n;
      r_cyc     <= w_cyc_n;
      r_divl    <= w_divl_n;
      r_par     <= w_par_n;
      r_tx      <= w_tx_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_bit_n   = r_bit_cnt;
    w_cyc_n   = r_cyc;
    w_divl_n  = r_divl;
    w_par_n   = r_par;
    w_pop     = 1'b0;
    w_tx_n    = 1'b1;

    case (r_state)
      S_IDLE: begin
        w_cyc_n = '0;
        if (!w_empty) w_pop = 1'b1;
      end
      S_START: begin
        if (w_bit_end) begin
          w_cyc_n   = '0;
          w_state_n = S_DATA;
        end else begin
          w_cyc_n = r_cyc + 16'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cyc_n   = '0;
          w_shift_n = {1'b0, r_shift[7:1]};
          w_bit_n   = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_n = S_PARITY;
`else
            w_state_n = S_STOP;
`endif
          end
        end else begin
          w_cyc_n = r_cyc + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_cyc_n   = '0;
          w_state_n = S_STOP;
        end else begin
          w_cyc_n = r_cyc + 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_cyc_n = '0;
          // Chain straight into the next frame when a byte is waiting.
          if (!w_empty) w_pop = 1'b1;
          else          w_state_n = S_IDLE;
        end else begin
          w_cyc_n = r_cyc + 16'd1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // Loading a frame latches the divisor, so later DIVISOR writes only
    // affect the following frame.
    if (w_pop) begin
      w_state_n = S_START;
      w_shift_n = w_head;
      w_bit_n   = '0;
      w_cyc_n   = '0;
      w_divl_n  = w_div_eff;
      w_par_n   = ^w_head;
    end

    // tx is registered from the next state so the pin never glitches.
    case (w_state_n)
      S_START:  w_tx_n = 1'b0;
      S_DATA:   w_tx_n = w_shift_n[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_n = w_par_n;
`endif
      default:  w_tx_n = 1'b1;
    endcase
  end

  assign tx = r_tx;

  // ---------------------------------------------------------------------------
  // Registered read port
  // ---------------------------------------------------------------------------
  logic [31:0] w_status, w_rdata;
  logic [31:0] r_rdata;
  logic        r_sel;
  logic        w_busy;

  assign w_busy   = (r_state != S_IDLE);
  assign w_status = {23'd0, PAR_FLAG, 4'(r_cnt), r_ovf, w_empty, w_full, w_busy};

  always_comb begin
    w_rdata = '0;
    if (w_hit_st) w_rdata = w_status;
    if (w_hit_dv) w_rdata = {16'd0, r_div};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
      r_sel   <= 1'b0;
    end else begin
      r_rdata <= w_rdata;
      r_sel   <= w_hit;
    end
  end

  assign dmem_data_out = r_rdata;
  assign sel_out       = r_sel;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed register checks plus
// randomized frames compared against a waveform model built from the frame
// rules (start bit, LSB-first data, optional even parity, stop bit).
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'hFFFFFFE0;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_DV = BASE + 32'h8;
`ifdef UART_TX_PARITY_EN
  localparam int          NB   = 11;
  localparam logic [31:0] PBIT = 32'h100;
`else
  localparam int          NB   = 10;
  localparam logic [31:0] PBIT = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        wren, sel, txo;
  logic [2:0]  f3;

  uart_tx_mmio dut (
    .clk(clk), .reset(reset), .dmem_address(addr), .dmem_data_in(wdata),
    .dmem_wren(wren), .funct3(f3), .dmem_data_out(rdata), .sel_out(sel),
    .tx(txo)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  logic txlog[$];
  logic expw[$];

  always @(negedge clk) txlog.push_back(txo);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    @(negedge clk);
    addr = a; wdata = d; f3 = f; wren = 1'b1;
    @(posedge clk);
    #1 wren = 1'b0; addr = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic s);
    @(negedge clk);
    addr = a; wren = 1'b0;
    @(posedge clk);
    #1 d = rdata; s = sel; addr = 32'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp,
                        input logic exp_sel);
    logic [31:0] d;
    logic        s;
    rd(a, d, s);
    chk(tag, d, exp);
    chk({tag, "_sel"}, {31'd0, s}, {31'd0, exp_sel});
  endtask

  // Model: one serial frame of byte b at div clocks per bit.
  function automatic void add_frame(input logic [7:0] b, input int div);
    repeat (div) expw.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (div) expw.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    repeat (div) expw.push_back(^b);
`endif
    repeat (div) expw.push_back(1'b1);
  endfunction

  function automatic void add_idle(input int n);
    repeat (n) expw.push_back(1'b1);
  endfunction

  function automatic void clear_logs();
    txlog.delete();
    expw.delete();
  endfunction

  task automatic chk_wave(input string tag);
    int   lim;
    int   first;
    logic got, want;
    lim = 0; first = -1; got = 1'bx; want = 1'bx;
    while (txlog.size() < expw.size() && lim < 5000) begin
      @(posedge clk);
      lim++;
    end
    if (txlog.size() < expw.size()) first = txlog.size();
    else begin
      for (int i = 0; i < expw.size(); i++)
        if (first < 0 && txlog[i] !== expw[i]) begin
          first = i; got = txlog[i]; want = expw[i];
        end
    end
    total++;
    assert (first == -1) else begin
      bad++;
      $error("FAIL %s: tx diverges at cycle %0d got %b want %b", tag, first, got, want);
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    logic [15:0] m_div, dv, eff;
    logic [31:0] d, dword;
    logic [2:0]  f;
    logic        s;
    logic [7:0]  bytes[$];
    int          n, bcnt, lim, queued;

    reset = 1'b0; addr = '0; wdata = '0; wren = 1'b0; f3 = 3'b010;
    repeat (3) @(posedge clk);
    #1 chk("tx_in_reset", {31'd0, txo}, 32'd1);
    chk("sel_in_reset", {31'd0, sel}, 32'd0);
    @(negedge clk) reset = 1'b1;
    #1;

    // ---- idle after reset, register window decode ----
    clear_logs(); add_idle(30);
    chk_wave("idle_after_reset");
    rd_chk("status_reset", A_ST, 32'h4 | PBIT, 1'b1);
    rd_chk("div_reset", A_DV, 32'd104, 1'b1);
    rd_chk("txdata_reads0", A_TX, 32'd0, 1'b1);
    rd_chk("off_c", BASE + 32'hC, 32'd0, 1'b0);
    rd_chk("outside", BASE + 32'h10, 32'd0, 1'b0);
    m_div = 16'd104;

    // ---- single frame 0x55 at div 4, busy window ----
    store(A_DV, 32'd4, 3'b010); m_div = 16'd4;
    clear_logs();
    store(A_TX, 32'h55, 3'b000);
    rd_chk("status_queued", A_ST, 32'h10 | PBIT, 1'b1);
    bcnt = 0; lim = 0;
    do begin
      rd(A_ST, d, s);
      if (d[0]) bcnt++;
      lim++;
    end while ((d[0] || bcnt == 0) && lim < 200);
    chk("busy_cycles", bcnt, NB * 4);
    chk("status_done", d, 32'h4 | PBIT);
    add_idle(2); add_frame(8'h55, 4); add_idle(4);
    chk_wave("frame_55");

    // ---- randomized frames with random divisor and access sizes ----
    for (int rep = 0; rep < 5; rep++) begin
      dv    = 16'($urandom_range(0, 6));
      dword = {16'($urandom), dv};
      f     = 3'($urandom_range(0, 2));
      store(A_DV, dword, f);
      m_div = (f == 3'b000) ? {m_div[15:8], dword[7:0]} : dword[15:0];
      rd_chk("div_rand", A_DV, {16'd0, m_div}, 1'b1);
      eff = (m_div == 16'd0) ? 16'd1 : m_div;
      n = $urandom_range(1, 4);
      bytes.delete();
      for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
      clear_logs(); add_idle(2);
      foreach (bytes[i]) begin
        store(A_TX, {24'($urandom), bytes[i]}, 3'($urandom_range(0, 2)));
        add_frame(bytes[i], int'(eff));
      end
      add_idle(3);
      chk_wave("frames_rand");
      rd_chk("status_rand", A_ST, 32'h4 | PBIT, 1'b1);
    end

    // ---- FIFO overflow: six back-to-back stores at div 16 ----
    store(A_DV, 32'd16, 3'b010);
    clear_logs(); add_idle(2);
    for (int i = 1; i <= 6; i++) store(A_TX, i, 3'b010);
    queued = (5 < 4) ? 5 : 4;   // first byte goes straight to the engine
    rd_chk("status_full_ovf", A_ST, PBIT | 32'h1 | 32'h2 | 32'h8 | (queued << 4), 1'b1);
    store(A_ST, 32'hFFFFFFF7, 3'b010);
    rd_chk("ovf_kept", A_ST, PBIT | 32'h4B, 1'b1);
    store(A_ST, 32'h8, 3'b010);
    rd_chk("ovf_cleared", A_ST, PBIT | 32'h43, 1'b1);
    for (int i = 1; i <= 5; i++) add_frame(8'(i), 16);
    add_idle(3);
    chk_wave("frames_ovf");
    rd_chk("status_after_ovf", A_ST, 32'h4 | PBIT, 1'b1);

    // ---- DIVISOR access sizes, div 0, mid-frame change ----
    do_reset();
    store(A_DV, 32'h123456AB, 3'b000);
    rd_chk("div_sb", A_DV, 32'h00AB, 1'b1);
    store(A_DV, 32'hFFFF1234, 3'b001);
    rd_chk("div_sh", A_DV, 32'h1234, 1'b1);
    store(A_DV, 32'h0, 3'b010);
    rd_chk("div_sw0", A_DV, 32'h0, 1'b1);
    clear_logs(); add_idle(2);
    store(A_TX, 32'hC3, 3'b010);
    add_frame(8'hC3, 1); add_idle(3);
    chk_wave("frame_div0");
    store(A_DV, 32'd3, 3'b010);
    clear_logs(); add_idle(2);
    store(A_TX, 32'h96, 3'b010);
    store(A_DV, 32'd7, 3'b010);
    store(A_TX, 32'h3C, 3'b010);
    add_frame(8'h96, 3); add_frame(8'h3C, 7); add_idle(3);
    chk_wave("div_midframe");
    store(BASE + 32'hC, 32'hFFFFFFFF, 3'b010);
    rd_chk("div_after_offc", A_DV, 32'd7, 1'b1);
    rd_chk("status_after_offc", A_ST, 32'h4 | PBIT, 1'b1);

    // ---- asynchronous reset during data bit 3 ----
    store(A_DV, 32'd4, 3'b010);
    store(A_TX, 32'hA5, 3'b010);
    store(A_TX, 32'h11, 3'b010);
    store(A_TX, 32'h22, 3'b010);
    repeat (16) @(posedge clk);
    #2 chk("tx_bit3", {31'd0, txo}, 32'd0);
    reset = 1'b0;
    #1 chk("tx_async_reset", {31'd0, txo}, 32'd1);
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    #1;
    rd_chk("status_post_reset", A_ST, 32'h4 | PBIT, 1'b1);
    rd_chk("div_post_reset", A_DV, 32'd104, 1'b1);
    clear_logs(); add_idle(200);
    chk_wave("no_stale_frames");

`ifdef UART_TX_PARITY_EN
    // ---- parity bit placement ----
    store(A_DV, 32'd2, 3'b010);
    clear_logs(); add_idle(2);
    store(A_TX, 32'h07, 3'b010);
    store(A_TX, 32'h03, 3'b010);
    add_frame(8'h07, 2); add_frame(8'h03, 2); add_idle(3);
    chk_wave("parity_frames");
    chk("parity_07", {31'd0, txlog[2 + 9 * 2]}, 32'd1);
    chk("parity_03", {31'd0, txlog[2 + 22 + 9 * 2]}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
